// File: rtl/inst_loader_pkg.sv
// Shared types and widths for the instruction loader.
// States, word widths and default sizes.
package inst_loader_pkg;

  localparam int WORD_W       = 32;
  localparam int INST_W       = 32;
  localparam int LDR_SIZE     = 1024;
  localparam int LOADER_LEN_W = $clog2(LDR_SIZE + 1);

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_RECV = 2'd1,
    LDR_FIN  = 2'd2
  } ldr_state_e;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Little-endian byte packer: collects 4 bytes into a word.
// clr_i drops partial state; push_i accepts byte_i; word_valid_o on 4th byte.
module inst_loader_byte_packer
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [7:0]        byte_i,
  output logic              word_valid_o,
  output logic [INST_W-1:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;

  // The 4th byte is never stored; it goes straight into the top lane.
  assign word_valid_o = push_i && (cnt_q == 2'd3);
  assign word_o       = {byte_i, asm_q};

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clr_i) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (push_i) begin
      cnt_d = cnt_q + 2'd1;
      unique case (cnt_q)
        2'd0: asm_d[7:0]   = byte_i;
        2'd1: asm_d[15:8]  = byte_i;
        2'd2: asm_d[23:16] = byte_i;
        2'd3: asm_d        = asm_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction memory loader: byte stream in, registered word writes out.
// Ports: start/len/abort control, byte valid/ready, mem write, busy/done/err.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int SIZE  = LDR_SIZE,
  parameter int LEN_W = LOADER_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  ldr_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  idx_inc;
  logic              eflag_q, eflag_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              pk_clr;
  logic              pk_push;
  logic              pk_wv;
  logic [INST_W-1:0] pk_word;

  assign byte_ready = (state_q == LDR_RECV);
  assign busy       = (state_q != LDR_IDLE);
  assign pk_push    = byte_valid && byte_ready;
  assign idx_inc    = idx_q + LEN_W'(1);

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign err       = err_q;

  inst_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (pk_clr),
    .push_i       (pk_push),
    .byte_i       (byte_data),
    .word_valid_o (pk_wv),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    eflag_d = eflag_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pk_clr  = 1'b0;
    unique case (state_q)
      LDR_IDLE: begin
        if (start) begin
          pk_clr = 1'b1;
          idx_d  = '0;
          unique case (1'b1)
            (len == '0): begin
              state_d = LDR_FIN;
            end
            ({1'b0, len} > (LEN_W+1)'(SIZE)): begin
              state_d = LDR_FIN;
              eflag_d = 1'b1;
            end
            default: begin
              len_d   = len;
              state_d = LDR_RECV;
            end
          endcase
        end
      end
      LDR_RECV: begin
        // Abort beats a completing word on the same edge.
        if (abort) begin
          pk_clr  = 1'b1;
          state_d = LDR_IDLE;
        end else if (pk_wv) begin
          we_d    = 1'b1;
          wdata_d = pk_word;
          addr_d  = WORD_W'({idx_q, 2'b00});
          idx_d   = idx_inc;
          if (idx_inc == len_q) state_d = LDR_FIN;
        end
      end
      LDR_FIN: begin
        done_d  = 1'b1;
        err_d   = eflag_q;
        eflag_d = 1'b0;
        state_d = LDR_IDLE;
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LDR_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      eflag_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      eflag_q <= eflag_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader.
// Drives byte streams, records writes and done pulses, checks by hand values.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int SIZE  = 1024;
  localparam int LEN_W = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              abort = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [INST_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  inst_loader #(.SIZE(SIZE), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t wr_q[$];
  int  acc_q[$];
  int  done_n = 0;
  int  done_cyc = 0;
  int  err_n = 0;
  int  err_alone = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) wr_q.push_back('{mem_addr, mem_wdata, cyc});
      if (done) begin
        done_n++;
        done_cyc = cyc;
        if (err) err_n++;
      end else if (err) begin
        err_alone++;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] v, input int n,
                      input bit tog, input bit ab_last);
    int i;
    int g;
    bit ok;
    i = 0;
    g = 0;
    while (i < n && g < 200) begin
      if (tog && (g % 2 == 1)) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = v[8*i +: 8];
      end
      ok = byte_valid && byte_ready;
      abort = ab_last && ok && (i == n - 1);
      tick();
      abort = 1'b0;
      if (ok) begin
        acc_q.push_back(cyc);
        i++;
      end
      g++;
    end
    byte_valid = 1'b0;
    check("send_cnt", 64'(i), 64'(n));
  endtask

  task automatic wait_done(input int prev);
    int k;
    k = 0;
    while (done_n == prev && k < 20) begin
      tick();
      k++;
    end
    check("done_seen", 64'(done_n > prev), 64'd1);
  endtask

  task automatic clr_logs();
    wr_q.delete();
    acc_q.delete();
  endtask

  task automatic run_two(input string tg, input bit tog);
    int dn;
    int en;
    clr_logs();
    dn = done_n;
    en = err_n;
    start_load(2);
    send(64'hDEADBEEF_12345678, 8, tog, 1'b0);
    check({tg, "_w2_we"}, 64'(mem_we), 64'd1);
    check({tg, "_w2_rdy"}, 64'(byte_ready), 64'd0);
    wait_done(dn);
    check({tg, "_nwr"}, 64'(wr_q.size()), 64'd2);
    if (wr_q.size() == 2 && acc_q.size() == 8) begin
      check({tg, "_a0"}, 64'(wr_q[0].a), 64'h0);
      check({tg, "_d0"}, 64'(wr_q[0].d), 64'h12345678);
      check({tg, "_a1"}, 64'(wr_q[1].a), 64'h4);
      check({tg, "_d1"}, 64'(wr_q[1].d), 64'hDEADBEEF);
      check({tg, "_c0"}, 64'(wr_q[0].c), 64'(acc_q[3]));
      check({tg, "_c1"}, 64'(wr_q[1].c), 64'(acc_q[7]));
      check({tg, "_dcyc"}, 64'(done_cyc), 64'(acc_q[7] + 1));
    end
    check({tg, "_err"}, 64'(err_n), 64'(en));
  endtask

  initial begin
    int dn;
    int en;

    // Reset values
    #12;
    check("rst_ctl", 64'({byte_ready, mem_we, busy, done, err}), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;
    tick();

    // Reset during RECV drops the partial word
    clr_logs();
    start_load(1);
    send(64'h2211, 2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy", 64'({busy, byte_ready}), 64'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_nwr", 64'(wr_q.size()), 64'd0);

    clr_logs();
    dn = done_n;
    start_load(1);
    send(64'h44332211, 4, 1'b0, 1'b0);
    check("l1_we", 64'(mem_we), 64'd1);
    check("l1_addr", 64'(mem_addr), 64'd0);
    check("l1_data", 64'(mem_wdata), 64'h44332211);
    check("l1_rdy", 64'(byte_ready), 64'd0);
    wait_done(dn);
    check("l1_nwr", 64'(wr_q.size()), 64'd1);
    check("l1_dcyc", 64'(done_cyc), 64'(acc_q[3] + 1));
    tick();
    check("l1_hold", 64'({mem_we, mem_wdata}), 64'h0_44332211);

    // Two-word loads, continuous and gappy
    run_two("cont", 1'b0);
    tick();
    run_two("togl", 1'b1);
    tick();

    // len == 0
    clr_logs();
    en = err_n;
    start_load(0);
    check("z_busy", 64'({busy, mem_we, done}), 64'b100);
    tick();
    check("z_done", 64'({done, err}), 64'b10);
    tick();
    check("z_after", 64'({done, busy}), 64'd0);
    check("z_nwr", 64'(wr_q.size()), 64'd0);

    // len == SIZE+1
    start_load(SIZE + 1);
    check("big_busy", 64'({busy, mem_we, done, err}), 64'b1000);
    tick();
    check("big_done", 64'({done, err}), 64'b11);
    tick();
    check("big_after", 64'({done, err, busy}), 64'd0);
    check("big_nwr", 64'(wr_q.size()), 64'd0);
    check("big_errn", 64'(err_n), 64'(en + 1));

    // Abort on the 4th byte of word 1
    clr_logs();
    dn = done_n;
    start_load(3);
    send(64'hCAFEF00D, 4, 1'b0, 1'b0);
    send(64'h0BADC0DE, 4, 1'b0, 1'b1);
    check("ab_now", 64'({mem_we, busy, byte_ready}), 64'd0);
    repeat (3) tick();
    check("ab_nwr", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() == 1)
      check("ab_d0", 64'(wr_q[0].d), 64'hCAFEF00D);
    check("ab_nodone", 64'(done_n), 64'(dn));
    check("ab_noerr", 64'(err_alone), 64'd0);

    // start while busy is ignored
    clr_logs();
    dn = done_n;
    start_load(2);
    send(64'h2211, 2, 1'b0, 1'b0);
    start = 1'b1;
    len   = LEN_W'(1);
    tick();
    start = 1'b0;
    send(64'h887766554433, 6, 1'b0, 1'b0);
    wait_done(dn);
    check("sb_nwr", 64'(wr_q.size()), 64'd2);
    if (wr_q.size() == 2) begin
      check("sb_d0", 64'(wr_q[0].d), 64'h44332211);
      check("sb_a1", 64'(wr_q[1].a), 64'h4);
      check("sb_d1", 64'(wr_q[1].d), 64'h88776655);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Write-side counterpart of the instruction memory: fills it with a program before the core runs.
- Accepts a byte stream over a valid/ready handshake (for example, from a UART or debug bridge).
- Packs every 4 bytes little-endian into one 32-bit instruction and drives a registered write port addressed like pc: byte address, word-aligned, index = addr/4.
- Holds the core via `busy` while loading and signals completion with a `done` pulse.

Parameters:
- SIZE, 1024: instruction memory depth in words; must equal the memory's SIZE.
- LEN_W, 11: width of the `len` port; must hold the value SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- len  in  LEN_W  number of 32-bit words to load; sampled with start.
- abort  in  1  cancel the load in progress.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  incoming program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable, one cycle per word.
- mem_addr  out  `WORD  byte address of the write; always a multiple of 4.
- mem_wdata  out  `INST_SIZE  instruction word to write.
- busy  out  1  load in progress; keeps the core stalled.
- done  out  1  one-cycle pulse at the end of a load.
- err  out  1  one-cycle pulse, coincident with done, for a rejected length.

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset `rst_n` is asynchronous and active-low.
  - Reset drives state to IDLE and clears every output and internal counter to 0, including mem_addr and mem_wdata.
  - Reset mid-load discards any partial word; no write is issued.
- States: IDLE, RECV, FIN.
  - IDLE: byte_ready=0, busy=0.
    - start with len==0 → FIN, no writes.
    - start with len>SIZE → FIN with the error flag set, no writes.
    - Otherwise latch len, clear word_idx and byte_cnt, → RECV.
  - RECV: byte_ready=1 and busy=1, both decoded from the registered state.
    - A byte is accepted on a clock edge where byte_valid && byte_ready.
    - Byte k of a word (k=0..3) goes to bits [8k+7:8k] of the assembly register.
    - On the 4th accepted byte, the following are registered at that same edge:
      - mem_we=1, mem_wdata = assembled word, mem_addr = word_idx*4.
      - word_idx increments; byte_cnt returns to 0.
    - Write latency: mem_we is visible in the cycle after the 4th byte's accepting edge, for exactly one cycle.
    - If the incremented word_idx equals len, the same edge moves the state to FIN, so byte_ready drops in the cycle where mem_we is high.
    - byte_valid low simply stalls; there is no timeout.
  - FIN: busy=1 for one cycle.
    - The next edge sets done=1 (and err=1 if flagged), clears the flag, → IDLE.
    - done and err are high for exactly one cycle.
- Abort:
  - Sampled in RECV; wins over everything else on that edge.
  - → IDLE, partial word discarded, no write (even if the 4th byte is accepted on the same edge).
  - No done or err pulse.
  - Words already written remain in memory.
- Ignored inputs: start outside IDLE; abort in IDLE or FIN.
- Address and data rules:
  - mem_addr is zero-extended to `WORD`.
  - Maximum address is (SIZE-1)*4; no wrap-around is possible because len ≤ SIZE.
  - mem_addr and mem_wdata hold their last values when mem_we=0.

Decomposition:
- common.vh gains:
  - state encodings LDR_IDLE, LDR_RECV, LDR_FIN;
  - LOADER_LEN_W, with default derived from SIZE.
- It reuses `WORD and `INST_SIZE.
- Natural sub-module: byte_packer. It contains the byte counter and the 32-bit little-endian shift/assembly register, exposes word_valid and word, and takes a clear input driven by abort and start.
- The FSM and word/address counter stay in inst_loader.

Test Plan:
- Reset mid-RECV after 2 bytes, then start len=1 with bytes 0x11,0x22,0x33,0x44 → no write before reset; after restart a single write, addr 0, data 0x44332211, then done.
- start len=2 with bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE, byte_valid always high:
  - writes (0x0, 0x12345678) and (0x4, 0xDEADBEEF), each one cycle after its 4th byte;
  - byte_ready low from the cycle of the 2nd write;
  - done pulse 2 cycles after the final accepting edge; err=0.
- Same load with byte_valid toggled every other cycle → identical writes and data, no extra or duplicated bytes.
- start len=0 → no mem_we, done=1 two cycles later, err=0. start len=SIZE+1 → no mem_we, done=1 with err=1.
- abort in the same cycle the 4th byte of word 1 is accepted (len=3) → only word 0 written, no done, busy low next cycle. start while busy → ignored, word_idx unaffected.
